// File: rtl/axis_fifo_sync_pkt.sv
`timescale 1ns/1ps
// Single-clock AXI-Stream FIFO: RAM plus first-word-fall-through output register,
// optional store-and-forward packet gating, occupancy/packet counters and threshold flags.
module axis_fifo_sync_pkt #(
   parameter int FIFO_DEPTH   = 256,
   parameter int BUS_WIDTH    = 1,
   parameter int USER_WIDTH   = 1,
   parameter int DEST_WIDTH   = 1,
   parameter int PACKET_MODE  = 0,
   parameter int ALMOST_FULL  = 240,
   parameter int ALMOST_EMPTY = 16,
   parameter int COUNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                     aclk,
   input  logic                     arst,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic [BUS_WIDTH*8-1:0]   s_axis_tdata,
   input  logic [BUS_WIDTH-1:0]     s_axis_tkeep,
   input  logic                     s_axis_tlast,
   input  logic [USER_WIDTH-1:0]    s_axis_tuser,
   input  logic [DEST_WIDTH-1:0]    s_axis_tdest,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [BUS_WIDTH*8-1:0]   m_axis_tdata,
   output logic [BUS_WIDTH-1:0]     m_axis_tkeep,
   output logic                     m_axis_tlast,
   output logic [USER_WIDTH-1:0]    m_axis_tuser,
   output logic [DEST_WIDTH-1:0]    m_axis_tdest,
   output logic [COUNT_WIDTH-1:0]   data_count,
   output logic [COUNT_WIDTH-1:0]   packet_count,
   output logic                     almost_full,
   output logic                     almost_empty
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int DATA_W  = BUS_WIDTH * 8;
   localparam int ENTRY_W = DATA_W + BUS_WIDTH + 1 + USER_WIDTH + DEST_WIDTH;
   localparam int LAST_BIT = USER_WIDTH + DEST_WIDTH;
   localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(FIFO_DEPTH);
   localparam logic [31:0] AF_TH = ALMOST_FULL;
   localparam logic [31:0] AE_TH = ALMOST_EMPTY;

   logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] count_d;
   logic [COUNT_WIDTH-1:0] pkt_q;
   logic [COUNT_WIDTH-1:0] pkt_d;
   logic [ENTRY_W-1:0]     out_q;
   logic                   out_valid;
   logic                   init_q;
   logic                   tready_q;
   logic                   draining_q;
   logic                   af_q;
   logic                   ae_q;

   logic                   full;
   logic                   wr_en;
   logic                   rd_en;
   logic                   ram_empty;
   logic                   load;
   logic                   rd_last;
   logic                   pkt_inc;
   logic                   pkt_dec;
   logic [ENTRY_W-1:0]     wr_entry;

   assign full      = (count_q == DEPTH_C);
   assign ram_empty = (count_q == COUNT_WIDTH'(out_valid));
   assign rd_last   = out_q[LAST_BIT];
   assign wr_entry  = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser, s_axis_tdest};

   // In packet mode the head beat is held back until a whole packet is stored, unless the
   // FIFO is full (an oversized packet) or such a packet is already part-way out.
   assign m_axis_tvalid = (PACKET_MODE != 0) ?
                          (out_valid && ((pkt_q != '0) || full || draining_q)) : out_valid;

   assign s_axis_tready = tready_q;
   assign wr_en = s_axis_tvalid && tready_q;
   assign rd_en = m_axis_tvalid && m_axis_tready;
   assign load  = !ram_empty && (!out_valid || rd_en);

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tdest} = out_q;
   assign data_count   = count_q;
   assign packet_count = pkt_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;

   // Next-state occupancy and packet counts shared by the state register and the flags.
   always_comb begin
      count_d = count_q;
      pkt_d   = pkt_q;
      pkt_inc = wr_en && s_axis_tlast;
      pkt_dec = rd_en && rd_last && (pkt_q != '0);
      if (wr_en && !rd_en) begin
         count_d = count_q + COUNT_WIDTH'(1);
      end else if (rd_en && !wr_en) begin
         count_d = count_q - COUNT_WIDTH'(1);
      end
      if (pkt_inc && !pkt_dec && (pkt_q != DEPTH_C)) begin
         pkt_d = pkt_q + COUNT_WIDTH'(1);
      end else if (pkt_dec && !pkt_inc) begin
         pkt_d = pkt_q - COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // tready is held low for one extra cycle after reset via init_q.
   always_ff @(posedge aclk) begin
      if (arst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         pkt_q      <= '0;
         out_q      <= '0;
         out_valid  <= 1'b0;
         init_q     <= 1'b0;
         tready_q   <= 1'b0;
         draining_q <= 1'b0;
         af_q       <= 1'b0;
         ae_q       <= 1'b1;
      end else begin
         init_q   <= 1'b1;
         tready_q <= init_q && (count_d != DEPTH_C);
         count_q  <= count_d;
         pkt_q    <= pkt_d;
         af_q     <= (32'(count_d) >= AF_TH);
         ae_q     <= (32'(count_d) <= AE_TH);
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (load) begin
            out_q     <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + PTR_W'(1);
            out_valid <= 1'b1;
         end else if (rd_en) begin
            out_valid <= 1'b0;
         end
         if (rd_en) begin
            draining_q <= !rd_last;
         end
      end
   end

endmodule
